fa_exerciser: RTL

Self-checking stimulus sequencer for the board's one-bit full adder. Where the switch-driven top applies operands by hand and shows sum/carry on LEDs, this block drives the adder's a/b/cin inputs itself. It steps through all eight input combinations and samples sum/cout after a settle window. It compares each result against the expected value and reports per-vector failures, an error count and a pass flag, so the adder can be checked on hardware without touching the switches.

---
 rtl/fa_exerciser.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fa_exerciser.sv
// fa_exerciser
//   Drives the board's one-bit full adder through all eight a/b/cin
//   combinations, waits a settle window per vector, samples sum/cout and
//   records which vectors disagreed with the ideal adder.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before its check cycle (1..15)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level-sampled sweep request (ignored while busy)
//   fa_a       out  adder operand a   (vector bit 0)
//   fa_b       out  adder operand b   (vector bit 1)
//   fa_cin     out  adder carry-in    (vector bit 2)
//   fa_sum     in   adder sum output
//   fa_cout    in   adder carry output
//   busy       out  sweep in progress
//   done       out  sweep finished, results final
//   pass       out  done with no failing vector
//   err_count  out  number of failing vectors in the last sweep
//   fail_vec   out  bit v set when vector v failed
module fa_exerciser #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       fa_a,
  output logic       fa_b,
  output logic       fa_cin,
  input  logic       fa_sum,
  input  logic       fa_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic [3:0] r_err;
  logic [7:0] r_fail;

  logic       w_busy;
  logic       w_accept;
  logic       w_exp_sum;
  logic       w_exp_cout;
  logic       w_mismatch;

  assign w_busy     = (r_state == SETTLE) || (r_state == CHECK);
  // A start is only honoured from the two resting states.
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));

  // Ideal full adder for the vector currently applied.
  assign w_exp_sum  = r_vec[0] ^ r_vec[1] ^ r_vec[2];
  assign w_exp_cout = (r_vec[0] & r_vec[1]) | (r_vec[0] & r_vec[2]) | (r_vec[1] & r_vec[2]);
  assign w_mismatch = (fa_sum != w_exp_sum) || (fa_cout != w_exp_cout);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SETTLE;
      SETTLE:  if (r_cnt == CNT_LAST) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = (r_vec == 3'd7) ? DONE : SETTLE;
      DONE:    if (start) w_state_nxt = SETTLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= 3'd0;
      r_cnt   <= 4'd0;
      r_err   <= 4'd0;
      r_fail  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vec  <= 3'd0;
        r_cnt  <= 4'd0;
        r_err  <= 4'd0;
        r_fail <= 8'd0;
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (r_state == CHECK) begin
        if (w_mismatch) begin
          r_fail[r_vec] <= 1'b1;
          r_err         <= r_err + 4'd1;
        end
        if (r_vec != 3'd7) begin
          r_vec <= r_vec + 3'd1;
          r_cnt <= 4'd0;
        end
      end
    end
  end

  // Operands are parked at zero whenever no sweep is running.
  assign fa_a      = w_busy & r_vec[0];
  assign fa_b      = w_busy & r_vec[1];
  assign fa_cin    = w_busy & r_vec[2];
  assign busy      = w_busy;
  assign done      = (r_state == DONE);
  assign pass      = done && (r_err == 4'd0);
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule
